// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory fetch channel: a request/acknowledge pair carrying a word
// address out and an instruction word back, with variable response latency.
interface instruction_fetch_unit_if #(
    parameter int N = 32
);
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ack;
    logic [N-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, talks to instruction memory over req/ack and loads
// the IF/ID register, with stall back-pressure and redirect flush.
module instruction_fetch_unit #(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    instruction_fetch_unit_if.master  imem,
    input  logic                      stall,
    input  logic                      redirect,
    input  logic [N-1:0]              redirect_pc,
    output logic [N-1:0]              IFID_Instruction,
    output logic [N-1:0]              IFID_PC,
    output logic                      IFID_Valid
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        DROP = 2'd1,
        HELD = 2'd2
    } state_e;

    state_e       state_q;
    logic [N-1:0] fetchPc_q;
    logic [N-1:0] nextPc_q;
    logic [N-1:0] bufInstr_q;
    logic [N-1:0] bufPc_q;
    logic [N-1:0] ifidInstr_q;
    logic [N-1:0] ifidPc_q;
    logic         ifidValid_q;

    logic [N-1:0] redirectPcAligned;
    logic [N-1:0] fetchPcPlus4;
    logic         ifidCanLoad;

    assign redirectPcAligned = {redirect_pc[N-1:2], 2'b00};
    assign fetchPcPlus4      = fetchPc_q + N'(4);
    assign ifidCanLoad       = !ifidValid_q || !stall;

    assign imem.imem_req  = ((state_q == REQ) || (state_q == DROP)) && !rst;
    assign imem.imem_addr = fetchPc_q;

    assign IFID_Instruction = ifidInstr_q;
    assign IFID_PC          = ifidPc_q;
    assign IFID_Valid       = ifidValid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= REQ;
            fetchPc_q   <= RESET_PC;
            nextPc_q    <= RESET_PC;
            bufInstr_q  <= '0;
            bufPc_q     <= '0;
            ifidInstr_q <= '0;
            ifidPc_q    <= '0;
            ifidValid_q <= 1'b0;
        end else begin
            case (state_q)
                REQ: begin
                    if (imem.imem_ack) begin
                        if (redirect) begin
                            fetchPc_q <= redirectPcAligned;
                        end else begin
                            fetchPc_q <= fetchPcPlus4;
                            if (ifidCanLoad) begin
                                ifidInstr_q <= imem.imem_rdata;
                                ifidPc_q    <= fetchPc_q;
                                ifidValid_q <= 1'b1;
                            end else begin
                                bufInstr_q <= imem.imem_rdata;
                                bufPc_q    <= fetchPc_q;
                                state_q    <= HELD;
                            end
                        end
                    end else if (redirect) begin
                        // The pending request must keep its address until acked,
                        // so the new target waits in nextPc_q.
                        nextPc_q <= redirectPcAligned;
                        state_q  <= DROP;
                    end
                end
                DROP: begin
                    if (imem.imem_ack) begin
                        fetchPc_q <= redirect ? redirectPcAligned : nextPc_q;
                        state_q   <= REQ;
                    end else if (redirect) begin
                        nextPc_q <= redirectPcAligned;
                    end
                end
                HELD: begin
                    if (redirect) begin
                        fetchPc_q <= redirectPcAligned;
                        state_q   <= REQ;
                    end else if (!stall) begin
                        ifidInstr_q <= bufInstr_q;
                        ifidPc_q    <= bufPc_q;
                        ifidValid_q <= 1'b1;
                        state_q     <= REQ;
                    end
                end
                default: begin
                    state_q <= REQ;
                end
            endcase

            // Flush wins over any load made in the same cycle.
            if (redirect) begin
                ifidValid_q <= 1'b0;
            end
        end
    end

endmodule
